// File: rtl/riscv_pkg.sv
// Shared RV64I encoding definitions: opcodes, micro-op class codes, ALU op
// codes, load/store width codes and the combinational micro-op encoder.
package riscv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    CLS_R      = 3'b000,
    CLS_I      = 3'b001,
    CLS_LOAD   = 3'b010,
    CLS_STORE  = 3'b011,
    CLS_BRANCH = 3'b100
  } inst_class_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_SLL = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SRL = 4'b0100,
    ALU_SRA = 4'b0101,
    ALU_OR  = 4'b0110,
    ALU_AND = 4'b0111,
    ALU_SLT = 4'b1000
  } alu_op_e;

  // Load width codes (micro-op side, not funct3)
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;
  localparam logic [2:0] LD_LD  = 3'b101;

  // Store width codes coincide with funct3
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;
  localparam logic [1:0] ST_SD = 2'b11;

  typedef struct packed {
    logic        legal;
    logic [31:0] inst;
  } enc_t;

  function automatic logic [2:0] alu_funct3(input logic [3:0] op);
    case (op)
      ALU_SLL:          return 3'b001;
      ALU_XOR:          return 3'b100;
      ALU_SRL, ALU_SRA: return 3'b101;
      ALU_OR:           return 3'b110;
      ALU_AND:          return 3'b111;
      ALU_SLT:          return 3'b010;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] load_funct3(input logic [2:0] op);
    case (op)
      LD_LB:   return 3'b000;
      LD_LH:   return 3'b001;
      LD_LW:   return 3'b010;
      LD_LBU:  return 3'b100;
      LD_LHU:  return 3'b101;
      LD_LD:   return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  // Word content is meaningless when legal=0; it is never written anywhere.
  function automatic enc_t encode(input logic [2:0]  cls,
                                  input logic [3:0]  op,
                                  input logic [4:0]  rd,
                                  input logic [4:0]  rs1,
                                  input logic [4:0]  rs2,
                                  input logic [12:0] imm);
    enc_t       e;
    logic       alu_ok;
    logic       is_shift;
    logic [2:0] f3;
    e.legal  = 1'b0;
    e.inst   = '0;
    alu_ok   = (op <= ALU_SLT);
    is_shift = (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    f3       = alu_funct3(op);
    case (cls)
      CLS_R: begin
        e.legal = alu_ok;
        e.inst  = {((op == ALU_SUB) || (op == ALU_SRA)) ? 7'b0100000 : 7'b0000000,
                   rs2, rs1, f3, rd, OPC_R};
      end
      CLS_I: begin
        e.legal = alu_ok && (op != ALU_SUB);
        // Shift-immediates carry a 6-bit shamt; the upper bits select srai.
        e.inst  = is_shift ?
                  {(op == ALU_SRA) ? 6'b010000 : 6'b000000, imm[5:0], rs1, f3, rd, OPC_I} :
                  {imm[11:0], rs1, f3, rd, OPC_I};
      end
      CLS_LOAD: begin
        e.legal = !op[3] && (op[2:0] <= LD_LD);
        e.inst  = {imm[11:0], rs1, load_funct3(op[2:0]), rd, OPC_LOAD};
      end
      CLS_STORE: begin
        e.legal = (op[3:2] == 2'b00);
        e.inst  = {imm[11:5], rs2, rs1, 1'b0, op[1:0], imm[4:0], OPC_STORE};
      end
      CLS_BRANCH: begin
        // funct3 010/011 are unassigned; odd offsets cannot be encoded.
        e.legal = !op[3] && (op[2:1] != 2'b01) && !imm[0];
        e.inst  = {imm[12], imm[10:5], rs2, rs1, op[2:0], imm[4:1], imm[11], OPC_BRANCH};
      end
      default: e.legal = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO with registered storage and show-ahead read.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty, level.
// The caller must not push while full nor pop while empty.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/riscv_inst_encoder.sv
// Encodes decoded RV64I micro-ops (R, I-ALU, load, store, branch) into 32-bit
// instruction words, queues them and drains them with sequential byte
// addresses for instruction-memory fill.
// Ports: clk, rst (sync, active-high); in_valid/in_ready plus in_class, in_op,
// in_rd, in_rs1, in_rs2, in_imm micro-op fields; out_valid/out_ready with
// out_inst and out_addr; err_illegal pulse, illegal_cnt (saturating), level.
module riscv_inst_encoder
  import riscv_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_class,
  input  logic [3:0]             in_op,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [12:0]            in_imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   err_illegal,
  output logic [7:0]             illegal_cnt,
  output logic [$clog2(DEPTH):0] level
);

  enc_t enc;
  logic full;
  logic empty;
  logic accept;
  logic push;
  logic pop;

  assign enc       = encode(in_class, in_op, in_rd, in_rs1, in_rs2, in_imm);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready;
  // Illegal micro-ops are consumed from the input but never queued.
  assign push      = accept && enc.legal;
  assign pop       = out_valid && out_ready;

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (enc.inst),
    .pop   (pop),
    .dout  (out_inst),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_addr    <= BASE_ADDR;
      err_illegal <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      if (pop) out_addr <= out_addr + ADDR_W'(4);
      err_illegal <= accept && !enc.legal;
      if (accept && !enc.legal && (illegal_cnt != 8'hFF))
        illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_riscv_inst_encoder.sv
module tb_riscv_inst_encoder;

  localparam int          DEPTH  = 4;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0;

  // funct3 per ALU code 0..8 and per load code 0..5
  localparam int ALU_F3 [9] = '{0, 0, 1, 4, 5, 5, 6, 7, 2};
  localparam int LD_F3  [6] = '{0, 1, 2, 4, 5, 3};

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [2:0]             in_class;
  logic [3:0]             in_op;
  logic [4:0]             in_rd;
  logic [4:0]             in_rs1;
  logic [4:0]             in_rs2;
  logic [12:0]            in_imm;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_inst;
  logic [ADDR_W-1:0]      out_addr;
  logic                   err_illegal;
  logic [7:0]             illegal_cnt;
  logic [$clog2(DEPTH):0] level;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_inst_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_class    (in_class),
    .in_op       (in_op),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_addr    (out_addr),
    .err_illegal (err_illegal),
    .illegal_cnt (illegal_cnt),
    .level       (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built field-by-field from the ISA formats.
  function automatic logic [32:0] model_enc(input logic [2:0] cls, input logic [3:0] op,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [12:0] imm);
    logic [31:0] w;
    bit ok;
    int o;
    w  = '0;
    ok = 0;
    o  = int'(op);
    case (cls)
      3'd0: if (o <= 8) begin
        ok = 1; w[6:0] = 7'h33; w[11:7] = rd; w[14:12] = 3'(ALU_F3[o]);
        w[19:15] = rs1; w[24:20] = rs2; w[30] = (o == 1 || o == 5);
      end
      3'd1: if (o <= 8 && o != 1) begin
        ok = 1; w[6:0] = 7'h13; w[11:7] = rd; w[14:12] = 3'(ALU_F3[o]); w[19:15] = rs1;
        if (o == 2 || o == 4 || o == 5) begin
          w[25:20] = imm[5:0]; w[30] = (o == 5);
        end else begin
          w[31:20] = imm[11:0];
        end
      end
      3'd2: if (o <= 5) begin
        ok = 1; w[6:0] = 7'h03; w[11:7] = rd; w[14:12] = 3'(LD_F3[o]);
        w[19:15] = rs1; w[31:20] = imm[11:0];
      end
      3'd3: if (o <= 3) begin
        ok = 1; w[6:0] = 7'h23; w[11:7] = imm[4:0]; w[14:12] = 3'(o);
        w[19:15] = rs1; w[24:20] = rs2; w[31:25] = imm[11:5];
      end
      3'd4: if (o <= 7 && o != 2 && o != 3 && imm[0] == 1'b0) begin
        ok = 1; w[6:0] = 7'h63; w[7] = imm[11]; w[11:8] = imm[4:1]; w[14:12] = 3'(o);
        w[19:15] = rs1; w[24:20] = rs2; w[30:25] = imm[10:5]; w[31] = imm[12];
      end
      default: ok = 0;
    endcase
    return {ok, w};
  endfunction

  // Transaction-level model of the queue, address counter and error counter.
  logic [31:0] mq[$];
  logic [31:0] m_addr = BASE;
  int          m_cnt = 0;
  bit          m_err = 0;
  bit          started = 0;

  always @(posedge clk) begin
    logic [32:0] e;
    bit acc;
    bit pp;
    e = model_enc(in_class, in_op, in_rd, in_rs1, in_rs2, in_imm);
    if (rst) begin
      mq.delete();
      m_addr = BASE;
      m_cnt  = 0;
      m_err  = 0;
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      pp  = (mq.size() > 0) && out_ready;
      if (pp) begin
        void'(mq.pop_front());
        m_addr = m_addr + 32'd4;
      end
      if (acc && e[32]) mq.push_back(e[31:0]);
      m_err = acc && !e[32];
      if (acc && !e[32] && m_cnt < 255) m_cnt++;
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("level", 64'(level), 64'(mq.size()));
      chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      chk("out_addr", 64'(out_addr), 64'(m_addr));
      chk("err_illegal", 64'(err_illegal), 64'(m_err));
      chk("illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
      if (mq.size() != 0) chk("out_inst", 64'(out_inst), 64'(mq[0]));
    end
  end

  task automatic set_fields(input logic [2:0] c, input logic [3:0] o, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [12:0] im);
    in_class = c; in_op = o; in_rd = d; in_rs1 = s1; in_rs2 = s2; in_imm = im;
    in_valid = 1'b1;
  endtask

  // Holds in_valid until an edge with in_ready high, then drops it.
  task automatic wait_accept();
    bit acc;
    bit done;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) done = 1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  task automatic send(input logic [2:0] c, input logic [3:0] o, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [12:0] im);
    set_fields(c, o, d, s1, s2, im);
    wait_accept();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_class = '0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming encodings, consumer always ready
    send(3'd0, 4'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    chk("lit_add", 64'(out_inst), 64'h002081B3);
    chk("lit_add_addr", 64'(out_addr), 64'h0);
    send(3'd0, 4'd1, 5'd5, 5'd6, 5'd7, 13'd0);
    chk("lit_sub", 64'(out_inst), 64'h407302B3);
    chk("lit_sub_addr", 64'(out_addr), 64'h4);
    send(3'd1, 4'd0, 5'd1, 5'd0, 5'd0, 13'hFFF);
    chk("lit_addi", 64'(out_inst), 64'hFFF00093);
    send(3'd2, 4'd5, 5'd5, 5'd2, 5'd0, 13'd16);
    chk("lit_ld", 64'(out_inst), 64'h01013283);
    send(3'd3, 4'd3, 5'd9, 5'd1, 5'd2, 13'd8);
    chk("lit_sd", 64'(out_inst), 64'h0020B423);
    send(3'd4, 4'd0, 5'd7, 5'd1, 5'd2, 13'd8);
    chk("lit_beq", 64'(out_inst), 64'h00208463);
    send(3'd1, 4'd5, 5'd4, 5'd5, 5'd9, 13'h7C3);
    chk("lit_srai", 64'(out_inst), 64'h4032D213);
    send(3'd0, 4'd2, 5'd8, 5'd9, 5'd10, 13'h1FFF);
    send(3'd0, 4'd5, 5'd31, 5'd30, 5'd29, 13'd0);
    send(3'd0, 4'd6, 5'd1, 5'd2, 5'd3, 13'd0);
    send(3'd0, 4'd8, 5'd4, 5'd5, 5'd6, 13'd0);
    send(3'd1, 4'd2, 5'd2, 5'd3, 5'd4, 13'h0FF);
    send(3'd1, 4'd4, 5'd2, 5'd3, 5'd4, 13'h03F);
    send(3'd1, 4'd7, 5'd6, 5'd7, 5'd8, 13'h800);
    send(3'd2, 4'd3, 5'd10, 5'd11, 5'd12, 13'hABC);
    send(3'd2, 4'd4, 5'd10, 5'd11, 5'd12, 13'h1FF);
    send(3'd2, 4'd2, 5'd1, 5'd1, 5'd1, 13'h004);
    send(3'd3, 4'd0, 5'd3, 5'd4, 5'd5, 13'hFFF);
    send(3'd3, 4'd1, 5'd3, 5'd4, 5'd5, 13'h7E1);
    send(3'd4, 4'd1, 5'd0, 5'd8, 5'd9, 13'h1FF0);
    send(3'd4, 4'd7, 5'd0, 5'd12, 5'd13, 13'h0FFE);
    send(3'd4, 4'd4, 5'd0, 5'd14, 5'd15, 13'h0802);
    @(posedge clk);
    #1;

    // Fill to DEPTH with consumer stalled, hold a fifth push
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'd0, 4'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 13'd0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_level", 64'(level), 64'd4);
    set_fields(3'd1, 4'd0, 5'd9, 5'd9, 5'd0, 13'h123);
    repeat (3) @(posedge clk);
    #1;
    chk("held_level", 64'(level), 64'd4);
    chk("held_head_addr", 64'(out_addr), 64'h0);
    out_ready = 1'b1;
    wait_accept();
    for (int i = 0; i < 20 && out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_addr", 64'(out_addr), 64'd20);

    // Illegal micro-ops
    do_reset();
    send(3'd5, 4'd0, 5'd1, 5'd1, 5'd1, 13'd0);
    chk("ill_class_err", 64'(err_illegal), 64'd1);
    send(3'd4, 4'd0, 5'd0, 5'd1, 5'd2, 13'd3);
    chk("ill_branch_err", 64'(err_illegal), 64'd1);
    chk("ill_level", 64'(level), 64'd0);
    @(posedge clk);
    #1;
    chk("ill_err_clear", 64'(err_illegal), 64'd0);
    chk("ill_cnt2", 64'(illegal_cnt), 64'd2);
    send(3'd1, 4'd1, 5'd1, 5'd1, 5'd1, 13'd0);
    send(3'd0, 4'd9, 5'd1, 5'd1, 5'd1, 13'd0);
    send(3'd2, 4'd6, 5'd1, 5'd1, 5'd1, 13'd0);
    send(3'd2, 4'd8, 5'd1, 5'd1, 5'd1, 13'd0);
    send(3'd3, 4'd4, 5'd1, 5'd1, 5'd1, 13'd0);
    send(3'd4, 4'd2, 5'd1, 5'd1, 5'd1, 13'd0);
    send(3'd4, 4'd8, 5'd1, 5'd1, 5'd1, 13'd0);
    send(3'd7, 4'd0, 5'd1, 5'd1, 5'd1, 13'd0);
    chk("ill_cnt10", 64'(illegal_cnt), 64'd10);
    chk("ill_none_queued", 64'(level), 64'd0);
    set_fields(3'd6, 4'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    repeat (256) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("ill_sat", 64'(illegal_cnt), 64'd255);

    // Reset in the middle of operation
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(3'd3, 4'(i), 5'd0, 5'(i), 5'(i + 4), 13'(i * 8));
    chk("pre_rst_level", 64'(level), 64'd3);
    do_reset();
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_addr", 64'(out_addr), 64'(BASE));
    chk("mid_rst_cnt", 64'(illegal_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
